// File: rtl/muldiv_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, regA, regB, flush, input busy, done, hi, lo);
    modport slave  (input start, op, regA, regB, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit owning HI/LO: one shift-add or
// restoring-subtract step per cycle on operand magnitudes, sign fixed up in FIN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                busy_r, done_r;
    logic                is_div, neg_q, neg_r;
    logic [WIDTH-1:0]    hreg, lreg, oper;
    logic [WIDTH-1:0]    hi_r, lo_r;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    sgn_op, a_neg, b_neg;
    logic [WIDTH:0]          msum, dtrial;
    logic [2*WIDTH-1:0]      prod_fix;
    logic [WIDTH-1:0]        quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] negw(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign a_s    = bus.regA;
    assign b_s    = bus.regB;
    assign sgn_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_neg  = sgn_op && (a_s < 0);
    assign b_neg  = sgn_op && (b_s < 0);

    // Multiply keeps the running upper half in hreg and shifts the multiplier
    // out of lreg; divide keeps the partial remainder in hreg and the
    // dividend/quotient in lreg.
    assign msum   = {1'b0, hreg} + (lreg[0] ? {1'b0, oper} : '0);
    assign dtrial = {hreg, lreg[WIDTH-1]} - {1'b0, oper};

    assign prod_fix = neg2w({hreg, lreg}, neg_q);
    assign quo_fix  = negw(lreg, neg_q);
    assign rem_fix  = negw(hreg, neg_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            OP_MTHI: hi_r <= bus.regA;
                            OP_MTLO: lo_r <= bus.regA;
                            OP_MULT, OP_MULTU: begin
                                is_div <= 1'b0;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                                hreg   <= '0;
                                lreg   <= negw(bus.regB, b_neg);
                                oper   <= negw(bus.regA, a_neg);
                                cnt    <= '0;
                                busy_r <= 1'b1;
                                state  <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                is_div <= 1'b1;
                                cnt    <= '0;
                                busy_r <= 1'b1;
                                if (bus.regB == '0) begin
                                    // Divide by zero skips iteration: lo=all ones, hi=dividend.
                                    neg_q  <= 1'b0;
                                    neg_r  <= 1'b0;
                                    hreg   <= bus.regA;
                                    lreg   <= '1;
                                    done_r <= 1'b1;
                                    state  <= FIN;
                                end else begin
                                    neg_q  <= a_neg ^ b_neg;
                                    neg_r  <= a_neg;
                                    hreg   <= '0;
                                    lreg   <= negw(bus.regA, a_neg);
                                    oper   <= negw(bus.regB, b_neg);
                                    state  <= RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (is_div) begin
                            if (!dtrial[WIDTH]) begin
                                hreg <= dtrial[WIDTH-1:0];
                                lreg <= {lreg[WIDTH-2:0], 1'b1};
                            end else begin
                                hreg <= {hreg[WIDTH-2:0], lreg[WIDTH-1]};
                                lreg <= {lreg[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            hreg <= msum[WIDTH:1];
                            lreg <= {msum[0], lreg[WIDTH-1:1]};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            done_r <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                FIN: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                    if (!bus.flush) begin
                        if (is_div) begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end else begin
                            {hi_r, lo_r} <= prod_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r && !bus.flush;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, scoreboard queue and
// hand-written flush/reset sequences.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          ebusy;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] exp_q[$];
    int          nchk  = 0;
    int          nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        case (o)
            3'd1: res = 64'(sa * sb);
            3'd2: res = ua * ub;
            3'd3: begin
                if (b == 32'h0) res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'h0) res = {a, 32'hFFFFFFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int ebusy);
        int bc, dc, n;
        logic [63:0] e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.regA  = a;
        bus.regB  = b;
        exp_q.push_back({eh, el});
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bc = 0;
        dc = 0;
        n  = 0;
        while (bus.busy && n < 200) begin
            bc++;
            if (bus.done) dc++;
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            nchk++;
            nfail++;
            $display("FAIL %s timeout: busy still high after %0d cycles, want low", nm, n);
        end
        chk({nm, " busy cycles"}, 32'(bc), 32'(ebusy));
        chk({nm, " done pulses"}, 32'(dc), (ebusy > 0) ? 32'd1 : 32'd0);
        if (exp_q.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL %s: scoreboard empty, want one entry", nm);
        end else begin
            e = exp_q.pop_front();
            chk({nm, " hi"}, bus.hi, e[63:32]);
            chk({nm, " lo"}, bus.lo, e[31:0]);
        end
    endtask

    initial begin
        int dc;
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [63:0] m;

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.regA  = '0;
        bus.regB  = '0;
        bus.flush = 1'b0;

        tbl.push_back('{"multu_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33});
        tbl.push_back('{"mult_neg",   3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33});
        tbl.push_back('{"mult_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33});
        tbl.push_back('{"divu_100_7", 3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       33});
        tbl.push_back('{"div_m7_2",   3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33});
        tbl.push_back('{"div_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33});
        tbl.push_back('{"div_by0",    3'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1});
        tbl.push_back('{"divu_by0",   3'd4, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'hFFFFFFFF, 1});
        tbl.push_back('{"mthi",       3'd5, 32'hAAAA5555, 32'h00000000, 32'hAAAA5555, 32'hFFFFFFFF, 0});
        tbl.push_back('{"mtlo",       3'd6, 32'h12345678, 32'h00000000, 32'hAAAA5555, 32'h12345678, 0});

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset hi", bus.hi, 32'h0);
        chk("reset lo", bus.lo, 32'h0);

        foreach (tbl[i])
            do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, tbl[i].ebusy);

        // Ops 0 and 7 leave everything untouched
        do_op("op_none", 3'd0, 32'h11111111, 32'h2, 32'hAAAA5555, 32'h12345678, 0);
        do_op("op_rsvd", 3'd7, 32'h11111111, 32'h2, 32'hAAAA5555, 32'h12345678, 0);

        // Flush with a same-cycle start in IDLE suppresses the start
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.regA = 32'h11111111; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0; bus.flush = 1'b0;
        chk("idle flush hi", bus.hi, 32'hAAAA5555);
        chk("idle flush busy", 32'(bus.busy), 32'd0);

        // Flush at RUN cycle 10 aborts without done and keeps HI/LO
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.regA = 32'd5; bus.regB = 32'd6;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        dc = 0;
        for (int c = 1; c < 10; c++) begin
            if (bus.done) dc++;
            @(negedge clk);
        end
        chk("flush pre busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush busy", 32'(bus.busy), 32'd0);
        for (int c = 0; c < 40; c++) begin
            if (bus.done) dc++;
            @(negedge clk);
        end
        chk("flush done pulses", 32'(dc), 32'd0);
        chk("flush hi", bus.hi, 32'hAAAA5555);
        chk("flush lo", bus.lo, 32'h12345678);

        // MTLO while busy is ignored, then reset mid-divide
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.regA = 32'd1000; bus.regB = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        for (int c = 1; c < 5; c++) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd6; bus.regA = 32'hBBBBBBBB;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        chk("busy mtlo lo", bus.lo, 32'h12345678);
        chk("busy mtlo busy", 32'(bus.busy), 32'd1);
        for (int c = 6; c < 20; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst hi", bus.hi, 32'h0);
        chk("midrst lo", bus.lo, 32'h0);
        do_op("post_rst_multu", 3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 33);

        // Random operations against the arithmetic model
        for (int k = 0; k < 8; k++) begin
            o = 3'($urandom_range(1, 4));
            a = $urandom;
            b = (k == 7) ? 32'h0 : $urandom;
            if (k == 3) b = 32'($urandom_range(1, 20));
            m = model(o, a, b);
            do_op($sformatf("rand%0d_op%0d", k, o), o, a, b, m[63:32], m[31:0],
                  (o >= 3'd3 && b == 32'h0) ? 1 : 33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit that owns the HI/LO register pair for the 5-stage MIPS32 pipeline. It sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and holds busy so the hazard logic stalls the pipeline. MFHI/MFLO read the hi/lo outputs directly. One shift-add or restoring-subtract step runs per cycle.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
clk    input   1      system clock, all state updates on rising edge
rst    input   1      reset, synchronous, active-high
start  input   1      op valid from EX stage; sampled only in IDLE
op     input   3      0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (ignored)
regA   input   WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
regB   input   WIDTH  rt operand: multiplier or divisor
flush  input   1      abort the in-flight mul/div; HI/LO unchanged
busy   output  1      high in RUN and FIN; pipeline stalls on MFHI/MFLO/muldiv while high
done   output  1      one-cycle pulse in FIN (HI/LO written at end of that cycle)
hi     output  WIDTH  HI register (remainder / upper product)
lo     output  WIDTH  LO register (quotient / lower product)

Behaviour:
- Reset: synchronous on rst high. State=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation discards the operation. Reset has priority over flush and start.
- States: IDLE, RUN, FIN.
- IDLE, start=1, op=MTHI: hi<=regA at that edge. busy stays 0, no done.
- IDLE, start=1, op=MTLO: lo<=regA at that edge. busy stays 0, no done.
- IDLE, start=1, op=1..4, divisor nonzero or multiply: latch |regA| and |regB|, where signed ops take the absolute value and unsigned ops use the operand as-is. Latch the result-sign flags: product/quotient is negative when the operand signs differ; remainder sign follows the dividend. Counter<=0, go to RUN.
- IDLE, start=1, op=DIV/DIVU, regB==0: go directly to FIN. Result is lo=all ones, hi=regA, for both signed and unsigned.
- IDLE, start=1, op 0 or 7: no effect.
- RUN: one step per cycle, exactly WIDTH cycles, then FIN.
  - Multiply: 2*WIDTH-bit shift-add, one multiplier bit per step, LSB first.
  - Divide: restoring division, one quotient bit per step, MSB first.
- FIN, one cycle: done=1. Apply sign correction: negate the 64-bit product, or negate the quotient and/or remainder. Write hi/lo at the end of the cycle, then go to IDLE.
- Latency: start accepted at edge E0. busy=1 for cycles E0+1 through E0+WIDTH+1 (33 cycles for WIDTH=32). New hi/lo are visible from cycle E0+WIDTH+2. Divide-by-zero: busy and done for 1 cycle only.
- start while busy: ignored, including MTHI/MTLO. Upstream must stall.
- flush in RUN or FIN: go to IDLE next edge, hi/lo keep their old values, no done pulse. flush in IDLE: no effect, and a same-cycle start is also suppressed.
- Signed overflow case -2^31 / -1: lo=0x80000000, hi=0. This is the natural result of the abs/negate scheme and must not be special-cased to a different value.
- hi/lo outputs are registered and change only at the FIN edge, the MTHI/MTLO edge, or on reset.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> busy exactly 33 cycles, done single pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT regA=0xFFFFFFFD (-3), regB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV regA=0x00001234, regB=0 -> busy 1 cycle, lo=0xFFFFFFFF, hi=0x00001234.
- MTHI 0xAAAA5555 then MTLO 0x12345678 -> hi/lo updated next cycle, busy never high. Start MULTU, pulse flush at RUN cycle 10 -> IDLE, no done, hi/lo still 0xAAAA5555/0x12345678.
- Start DIVU, assert MTLO start at RUN cycle 5 (ignored), then rst at RUN cycle 20 -> next cycle busy=0, hi=lo=0, state IDLE. A subsequent MULTU 3*4 completes normally with lo=12.
